// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: shares one I2C byte-write engine among NREQ requesters.
// Requesters are served round-robin. Each accepted transaction is issued to
// the engine, retried after a back-off gap when the slave NACKs, aborted on
// timeout, and closed with a one-cycle response pulse to its owner.
module i2c_txn_arbiter #(
  parameter int NREQ        = 4,
  parameter int MAX_RETRY   = 2,
  parameter int BACKOFF_CYC = 16,
  parameter int TIMEOUT_CYC = 1024,
  localparam int IW         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid_i,
  input  logic [7*NREQ-1:0] req_addr_i,
  input  logic [8*NREQ-1:0] req_data_i,
  output logic [NREQ-1:0]   req_ready_o,
  output logic [NREQ-1:0]   rsp_valid_o,
  output logic [1:0]        rsp_code_o,
  output logic              eng_start_o,
  output logic [6:0]        eng_addr_o,
  output logic [7:0]        eng_data_o,
  input  logic              eng_busy_i,
  input  logic              eng_done_i,
  input  logic              eng_nack_i,
  output logic              busy_o,
  output logic [IW-1:0]     grant_id_o
);

  localparam int RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TMAX = (TIMEOUT_CYC > BACKOFF_CYC) ? TIMEOUT_CYC : BACKOFF_CYC;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] BACKOFF_LOAD = TW'(BACKOFF_CYC - 1);
  localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_BACKOFF,
    S_RESP
  } state_e;

  typedef enum logic [1:0] {
    RSP_OK      = 2'b00,
    RSP_NACK    = 2'b01,
    RSP_TIMEOUT = 2'b10
  } rsp_code_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [6:0]      addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [TW-1:0]   timer_q, timer_d;
  rsp_code_e       code_q, code_d;

  logic            sel_found;
  logic [IW-1:0]   sel_id;

  // Requester index 'off' positions after 'base', wrapping at NREQ.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NREQ) sum = sum - NREQ;
    return IW'(sum);
  endfunction

  // Round-robin pick: nearest valid requester at or after rr_ptr.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    // Walk from the farthest offset down so the nearest match is written last.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid_i[wrap_add(rr_ptr_q, k)]) begin
        sel_found = 1'b1;
        sel_id    = wrap_add(rr_ptr_q, k);
      end
    end
  end

  // Next-state and output decode for the transaction FSM.
  always_comb begin
    // NOTE: every variable written here gets a default first so no path can
    // leave it unassigned, which is what would otherwise infer a latch.
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    addr_d      = addr_q;
    data_d      = data_q;
    retry_d     = retry_q;
    timer_d     = timer_q;
    code_d      = code_q;
    req_ready_o = '0;
    rsp_valid_o = '0;
    rsp_code_o  = '0;
    eng_start_o = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (sel_found && !eng_busy_i) begin
          req_ready_o[sel_id] = 1'b1;
          grant_d             = sel_id;
          addr_d              = req_addr_i[7*int'(sel_id) +: 7];
          data_d              = req_data_i[8*int'(sel_id) +: 8];
          retry_d             = '0;
          state_d             = S_ISSUE;
        end
      end
      S_ISSUE: begin
        eng_start_o = 1'b1;
        timer_d     = TIMEOUT_LOAD;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        // A frame ending in the expiry cycle still counts as completed.
        if (eng_done_i) begin
          if (!eng_nack_i) begin
            code_d  = RSP_OK;
            state_d = S_RESP;
          end else if (retry_q < RETRY_LIMIT) begin
            retry_d = retry_q + 1'b1;
            timer_d = BACKOFF_LOAD;
            state_d = S_BACKOFF;
          end else begin
            code_d  = RSP_NACK;
            state_d = S_RESP;
          end
        end else if (timer_q == '0) begin
          code_d  = RSP_TIMEOUT;
          state_d = S_RESP;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_BACKOFF: begin
        if (timer_q == '0) state_d = S_ISSUE;
        else               timer_d = timer_q - 1'b1;
      end
      S_RESP: begin
        rsp_valid_o[grant_q] = 1'b1;
        rsp_code_o           = code_q;
        retry_d              = '0;
        rr_ptr_d             = wrap_add(grant_q, 1);
        state_d              = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Pulses are suppressed while reset is held: an acceptance or response
    // issued in that cycle would be lost when the state is cleared.
    if (reset) begin
      req_ready_o = '0;
      rsp_valid_o = '0;
      rsp_code_o  = '0;
      eng_start_o = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge value of every other, independent of statement order.
    if (reset) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      retry_q  <= '0;
      timer_q  <= '0;
      code_q   <= RSP_OK;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      retry_q  <= retry_d;
      timer_q  <= timer_d;
      code_q   <= code_d;
    end
  end

  assign busy_o     = (state_q != S_IDLE);
  assign grant_id_o = grant_q;
  assign eng_addr_o = addr_q;
  assign eng_data_o = data_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// tb_i2c_txn_arbiter: directed and randomized transactions against a
// transaction-level model of round-robin ownership, retry and timeout rules.
module tb_i2c_txn_arbiter;

  localparam int NREQ        = 4;
  localparam int MAX_RETRY   = 2;
  localparam int BACKOFF_CYC = 16;
  localparam int TIMEOUT_CYC = 1024;
  localparam int IW          = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid_i;
  logic [7*NREQ-1:0] req_addr_i;
  logic [8*NREQ-1:0] req_data_i;
  logic [NREQ-1:0]   req_ready_o;
  logic [NREQ-1:0]   rsp_valid_o;
  logic [1:0]        rsp_code_o;
  logic              eng_start_o;
  logic [6:0]        eng_addr_o;
  logic [7:0]        eng_data_o;
  logic              eng_busy_i;
  logic              eng_done_i;
  logic              eng_nack_i;
  logic              busy_o;
  logic [IW-1:0]     grant_id_o;

  always #5 clk = ~clk;

  i2c_txn_arbiter #(
    .NREQ(NREQ), .MAX_RETRY(MAX_RETRY), .BACKOFF_CYC(BACKOFF_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o), .rsp_valid_o(rsp_valid_o), .rsp_code_o(rsp_code_o),
    .eng_start_o(eng_start_o), .eng_addr_o(eng_addr_o), .eng_data_o(eng_data_o),
    .eng_busy_i(eng_busy_i), .eng_done_i(eng_done_i), .eng_nack_i(eng_nack_i),
    .busy_o(busy_o), .grant_id_o(grant_id_o)
  );

  // Requester-side stimulus, copied onto the ports just after each rising edge.
  logic [NREQ-1:0]   tb_valid;
  logic [7*NREQ-1:0] tb_addr;
  logic [8*NREQ-1:0] tb_data;
  logic              tb_reset;
  logic              hold_busy;
  bit                sticky;
  bit                scramble_en;

  // Engine model: finishes a frame done_lat cycles after eng_start.
  int eng_cnt, nack_left, done_lat;
  bit eng_hang;

  // Event log for the transaction in progress.
  int              cyc;
  logic [NREQ-1:0] last_ready;
  bit              acc_seen;
  int              acc_cyc;
  logic [NREQ-1:0] acc_mask;
  int              start_q[$];
  logic [14:0]     start_ad_q[$];
  int              done_q[$];
  bit              rsp_seen;
  int              rsp_cyc;
  logic [NREQ-1:0] rsp_mask;
  logic [1:0]      rsp_code;
  logic [14:0]     rsp_ad;
  logic [IW-1:0]   rsp_gid;

  int m_ptr;
  int checks_total, checks_passed;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) begin
      checks_passed++;
    end else begin
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Model of round-robin ownership: first requester at or after the pointer.
  function automatic int model_pick(input logic [NREQ-1:0] m);
    for (int i = m_ptr; i < NREQ; i++) if (m[i]) return i;
    for (int i = 0; i < m_ptr; i++) if (m[i]) return i;
    return -1;
  endfunction

  task automatic clear_logs();
    acc_seen = 1'b0; acc_cyc = 0; acc_mask = '0;
    start_q.delete(); start_ad_q.delete(); done_q.delete();
    rsp_seen = 1'b0; rsp_cyc = 0; rsp_mask = '0; rsp_code = '0; rsp_ad = '0; rsp_gid = '0;
  endtask

  // One clock: drive just after the rising edge, observe on the falling edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (last_ready != '0) begin
      if (!sticky) tb_valid &= ~last_ready;
      if (scramble_en)
        for (int i = 0; i < NREQ; i++) begin
          tb_addr[7*i +: 7] = 7'($urandom);
          tb_data[8*i +: 8] = 8'($urandom);
        end
      last_ready = '0;
    end
    eng_done_i = 1'b0;
    eng_nack_i = 1'($urandom_range(0, 1));
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        eng_done_i = 1'b1;
        eng_nack_i = (nack_left > 0);
        if (nack_left > 0) nack_left--;
        eng_busy_i = 1'b0;
      end else begin
        eng_busy_i = 1'b1;
      end
    end else begin
      eng_busy_i = hold_busy;
    end
    reset       = tb_reset;
    req_valid_i = tb_valid;
    req_addr_i  = tb_addr;
    req_data_i  = tb_data;
    @(negedge clk);
    cyc++;
    if (eng_done_i) done_q.push_back(cyc);
    if (req_ready_o != '0) begin
      acc_seen = 1'b1; acc_cyc = cyc; acc_mask = req_ready_o; last_ready = req_ready_o;
    end
    if (eng_start_o) begin
      start_q.push_back(cyc);
      start_ad_q.push_back({eng_addr_o, eng_data_o});
      if (!eng_hang) eng_cnt = done_lat;
    end
    if (rsp_valid_o != '0) begin
      rsp_seen = 1'b1; rsp_cyc = cyc; rsp_mask = rsp_valid_o; rsp_code = rsp_code_o;
      rsp_ad = {eng_addr_o, eng_data_o}; rsp_gid = grant_id_o;
    end
  endtask

  // Run one transaction to its response and compare against the model.
  task automatic do_txn(input string tag, input logic [NREQ-1:0] mask,
                        input int nacks, input int lat, input bit hang);
    int g, exp_starts, budget;
    bit timed_out;
    logic [14:0] exp_ad;
    logic [1:0] exp_code;
    logic [NREQ-1:0] exp_mask;
    g = model_pick(mask);
    exp_mask = '0;
    exp_mask[g] = 1'b1;
    exp_ad = {tb_addr[7*g +: 7], tb_data[8*g +: 8]};
    timed_out = hang || (lat > TIMEOUT_CYC);
    if (timed_out) begin
      exp_starts = 1; exp_code = 2'b10;
    end else if (nacks > MAX_RETRY) begin
      exp_starts = MAX_RETRY + 1; exp_code = 2'b01;
    end else begin
      exp_starts = nacks + 1; exp_code = 2'b00;
    end
    nack_left = nacks; done_lat = lat; eng_hang = hang; tb_valid = mask;
    clear_logs();
    budget = 0;
    while (!rsp_seen && budget < 4000) begin
      cycle();
      budget++;
    end
    check({tag, ".rsp_seen"}, 32'(rsp_seen), 32'd1);
    check({tag, ".ready"}, 32'(acc_mask), 32'(exp_mask));
    check({tag, ".starts"}, start_q.size(), exp_starts);
    if (start_q.size() > 0) check({tag, ".accept_to_start"}, start_q[0] - acc_cyc, 1);
    for (int k = 0; k < start_q.size(); k++)
      check($sformatf("%s.start%0d_addr_data", tag, k), 32'(start_ad_q[k]), 32'(exp_ad));
    for (int k = 0; k + 1 < start_q.size() && k < done_q.size(); k++)
      check($sformatf("%s.backoff%0d", tag, k), start_q[k+1] - done_q[k], BACKOFF_CYC + 1);
    check({tag, ".rsp_valid"}, 32'(rsp_mask), 32'(exp_mask));
    check({tag, ".rsp_code"}, 32'(rsp_code), 32'(exp_code));
    check({tag, ".grant_id"}, 32'(rsp_gid), g);
    check({tag, ".held_addr_data"}, 32'(rsp_ad), 32'(exp_ad));
    if (timed_out && start_q.size() > 0)
      check({tag, ".timeout_latency"}, rsp_cyc - start_q[0], TIMEOUT_CYC + 1);
    else if (!timed_out && done_q.size() > 0)
      check({tag, ".done_to_rsp"}, rsp_cyc - done_q[done_q.size()-1], 1);
    m_ptr = (g + 1) % NREQ;
  endtask

  initial begin
    logic [NREQ-1:0] mask;
    int budget;
    int order [5] = '{0, 1, 2, 3, 0};
    logic [NREQ-1:0] exp_one;

    reset = 1'b1; req_valid_i = '0; req_addr_i = '0; req_data_i = '0;
    eng_busy_i = 1'b0; eng_done_i = 1'b0; eng_nack_i = 1'b0;
    tb_reset = 1'b1; tb_valid = '0; tb_addr = '0; tb_data = '0;
    hold_busy = 1'b0; sticky = 1'b0; scramble_en = 1'b0;
    eng_cnt = 0; nack_left = 0; done_lat = 1; eng_hang = 1'b0;
    cyc = 0; last_ready = '0; m_ptr = 0; checks_total = 0; checks_passed = 0;
    clear_logs();

    // Reset state.
    repeat (3) cycle();
    check("reset.busy", 32'(busy_o), 32'd0);
    check("reset.outputs", {req_ready_o, rsp_valid_o, rsp_code_o, eng_start_o,
                            eng_addr_o, eng_data_o, grant_id_o}, 32'd0);
    tb_reset = 1'b0;
    cycle();

    // Single request, clean completion.
    tb_addr[6:0] = 7'h50;
    tb_data[7:0] = 8'hA5;
    do_txn("single", 4'b0001, 0, 3, 1'b0);

    // Engine busy in IDLE blocks acceptance.
    clear_logs();
    hold_busy = 1'b1;
    tb_valid  = 4'b0010;
    repeat (8) cycle();
    check("busy_hold.no_accept", 32'(acc_seen), 32'd0);
    hold_busy = 1'b0;
    do_txn("busy_release", 4'b0010, 0, 2, 1'b0);

    // NACK on every attempt: three issues, back-off gaps, then a NACK code.
    do_txn("nack_all", 4'b0100, 3, 4, 1'b0);

    // Engine never finishes, then the next request is served normally.
    do_txn("timeout", 4'b0001, 0, 1, 1'b1);
    do_txn("after_timeout", 4'b1000, 0, 3, 1'b0);

    // Completion in the expiry cycle wins; one cycle later it is too late.
    do_txn("coincide", 4'b0010, 0, TIMEOUT_CYC, 1'b0);
    do_txn("late_done", 4'b0010, 0, TIMEOUT_CYC + 1, 1'b0);

    // A request withdrawn before acceptance gets neither handshake.
    clear_logs();
    hold_busy = 1'b1;
    tb_valid  = 4'b1000;
    repeat (4) cycle();
    tb_valid = '0;
    cycle();
    hold_busy = 1'b0;
    repeat (10) cycle();
    check("withdraw.no_accept", 32'(acc_seen), 32'd0);
    check("withdraw.no_rsp", 32'(rsp_seen), 32'd0);

    // Randomized traffic; request inputs are scrambled after acceptance.
    scramble_en = 1'b1;
    for (int t = 0; t < 12; t++) begin
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        tb_addr[7*i +: 7] = 7'($urandom);
        tb_data[8*i +: 8] = 8'($urandom);
      end
      do_txn($sformatf("rnd%0d", t), mask, $urandom_range(0, 3), $urandom_range(1, 6), 1'b0);
    end

    // Reset while waiting on the engine aborts without a response.
    clear_logs();
    eng_hang = 1'b1;
    tb_valid = 4'b0100;
    budget = 0;
    while (start_q.size() == 0 && budget < 50) begin
      cycle();
      budget++;
    end
    check("abort.started", start_q.size(), 1);
    repeat (5) cycle();
    check("abort.in_wait_busy", 32'(busy_o), 32'd1);
    tb_reset = 1'b1;
    cycle();
    tb_valid = '0;
    eng_hang = 1'b0;
    eng_cnt  = 0;
    cycle();
    check("abort.busy", 32'(busy_o), 32'd0);
    check("abort.outputs", {req_ready_o, rsp_valid_o, rsp_code_o, eng_start_o,
                            eng_addr_o, eng_data_o, grant_id_o}, 32'd0);
    tb_reset = 1'b0;
    m_ptr = 0;
    repeat (10) cycle();
    check("abort.no_rsp", 32'(rsp_seen), 32'd0);

    // All four requesting continuously: strict rotation starting at 0.
    sticky = 1'b1;
    for (int i = 0; i < 5; i++) begin
      do_txn($sformatf("rotate%0d", i), 4'b1111, 0, 2, 1'b0);
      exp_one = '0;
      exp_one[order[i]] = 1'b1;
      check($sformatf("rotate%0d.order", i), 32'(acc_mask), 32'(exp_one));
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
